// File: rtl/spi_sram_model.sv
// spi_sram_model: SPI mode-0 serial SRAM slave (READ 0x03 / WRITE 0x02) with a backdoor preload port.
module spi_sram_model #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 4096,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              sclk_i,
  input  logic              csb_i,
  input  logic              si_i,
  output logic              so_o,
  output logic              so_oe_o,
  output logic              busy_o,
  input  logic              load_en_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [7:0]        load_data_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ADDR_W + 1);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sclk_sync, csb_sync, si_sync;
  logic sclk_q, csb_q, sclk_s, csb_s, si_s;
  logic rise, fall, csb_fall, csb_rise;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [ADDR_W-1:0] sh, sh_n, sh_in;
  logic [AW-1:0] addr, addr_n, addr_inc, new_addr, load_idx;
  logic [7:0] tx, tx_n;
  logic rd, rd_n, so_n, oe_n, spi_we;
  logic [7:0] mem [DEPTH];
  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign csb_s    = csb_sync[SYNC_STAGES-1];
  assign si_s     = si_sync[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_q;
  assign fall     = ~sclk_s & sclk_q;
  assign csb_fall = csb_q & ~csb_s;
  assign csb_rise = ~csb_q & csb_s;
  assign busy_o   = ~csb_s;
  assign sh_in    = {sh[ADDR_W-2:0], si_s};
  assign new_addr = AW'(sh_in % ADDR_W'(DEPTH));
  assign load_idx = AW'(load_addr_i % ADDR_W'(DEPTH));
  assign addr_inc = (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sclk_sync <= '0;
      csb_sync  <= '1;
      si_sync   <= '0;
      sclk_q    <= 1'b0;
      csb_q     <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= '0;
      sh        <= '0;
      addr      <= '0;
      tx        <= '0;
      rd        <= 1'b0;
      so_o      <= 1'b0;
      so_oe_o   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], csb_i};
      si_sync   <= {si_sync[SYNC_STAGES-2:0], si_i};
      sclk_q    <= sclk_s;
      csb_q     <= csb_s;
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      sh        <= sh_n;
      addr      <= addr_n;
      tx        <= tx_n;
      rd        <= rd_n;
      so_o      <= so_n;
      so_oe_o   <= oe_n;
    end
  end
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    addr_n    = addr;
    tx_n      = tx;
    rd_n      = rd;
    so_n      = so_o;
    oe_n      = so_oe_o;
    spi_we    = 1'b0;
    if (csb_rise) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      so_n      = 1'b0;
      oe_n      = 1'b0;
    end else begin
      case (state)
        IDLE: if (csb_fall) begin
          state_n   = CMD;
          bit_cnt_n = '0;
        end
        CMD: if (rise) begin
          sh_n      = sh_in;
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == CW'(7)) begin
            bit_cnt_n = '0;
            rd_n      = sh_in[7:0] == 8'h03;
            state_n   = (sh_in[7:0] == 8'h03 || sh_in[7:0] == 8'h02) ? ADDR : IGNORE;
          end
        end
        ADDR: if (rise) begin
          sh_n      = sh_in;
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == CW'(ADDR_W - 1)) begin
            bit_cnt_n = '0;
            addr_n    = new_addr;
            state_n   = rd ? READ : WRITE;
            tx_n      = rd ? mem[new_addr] : tx;
            oe_n      = rd;
          end
        end
        READ: if (fall) begin
          so_n      = tx[7];
          tx_n      = {tx[6:0], 1'b0};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == CW'(7)) begin
            bit_cnt_n = '0;
            addr_n    = addr_inc;
            tx_n      = mem[addr_inc];
          end
        end
        WRITE: if (rise) begin
          sh_n      = sh_in;
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == CW'(7)) begin
            bit_cnt_n = '0;
            spi_we    = 1'b1;
            addr_n    = addr_inc;
          end
        end
        default: ;
      endcase
    end
  end
  // SPI commits only happen while busy, so the backdoor never contends for the port
  always_ff @(posedge clk) begin
    if (spi_we) mem[addr] <= sh_in[7:0];
    else if (load_en_i && !busy_o) mem[load_idx] <= load_data_i;
  end
endmodule
